// File: rtl/charge_meter_pkg.sv
// charge_meter_pkg: state/mode codes and active-low 7-segment glyphs for the charging meter
package charge_meter_pkg;
  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_IDLE = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_UNIT = 2'b01;
  localparam logic [1:0] MODE_PKG  = 2'b11;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DP    = 8'h7F;
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    return d > 4'd9 ? SEG_BLANK : SEG_DIGITS[d];
  endfunction
endpackage

// File: rtl/charge_meter_ctrl_seg_bcd_decode.sv
// seg_bcd_decode: binary to BCD by double dabble, then segments for one selected digit
module seg_bcd_decode
  import charge_meter_pkg::*;
#(
  parameter int VAL_W  = 8,
  parameter int DIGITS = 4,
  localparam int IW    = $clog2(DIGITS)
) (
  input  logic [VAL_W-1:0] val,
  input  logic [IW-1:0]    idx,
  output logic [7:0]       seg
);
  logic [4*DIGITS-1:0] bcd;
  always_comb begin
    bcd = '0;
    for (int i = VAL_W - 1; i >= 0; i--) begin
      for (int j = 0; j < DIGITS; j++)
        if (bcd[4*j +: 4] > 4'd4) bcd[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
      bcd = {bcd[4*DIGITS-2:0], val[i]};
    end
    // digit 0 is always shown; higher digits blank when nothing significant remains
    seg = (idx != '0 && (bcd >> (4 * idx)) == '0) ? SEG_BLANK : seg_of(bcd[4*idx +: 4]);
  end
endmodule

// File: rtl/charge_meter_ctrl.sv
// charge_meter_ctrl: charging-point session FSM with fee settlement and multiplexed 7-seg display
module charge_meter_ctrl
  import charge_meter_pkg::*;
#(
  parameter int MAX_UNITS   = 5,
  parameter int CNT_W       = 4,
  parameter int CHARGE_W    = 8,
  parameter int UNIT_FEE    = 2,
  parameter int DISC_MIN    = 3,
  parameter int BONUS       = 6,
  parameter int PKG_HIGH    = 10,
  parameter int PKG_LOW     = 15,
  parameter int PKG_FULL    = 20,
  parameter int TIMEOUT_CYC = 500000,
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                signal,
  input  logic                one,
  input  logic                ten,
  input  logic                high,
  input  logic                low,
  input  logic                cancel,
  output logic                work,
  output logic                hold_in,
  output logic [1:0]          mode,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    cnt,
  output logic [CHARGE_W-1:0] charge,
  output logic                fin,
  output logic                overflow,
  output logic [DIGITS-1:0]   en,
  output logic [7:0]          show
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int VW = CHARGE_W > CNT_W ? CHARGE_W : CNT_W;
  localparam logic [31:0] MAXC = 32'((2 ** CHARGE_W) - 1);
  function automatic logic [CHARGE_W-1:0] sat(input logic [31:0] v);
    return v > MAXC ? CHARGE_W'(MAXC) : CHARGE_W'(v);
  endfunction
  state_t st, st_n;
  logic [5:0] prev;
  logic e_one, e_ten, e_high, e_low, e_cancel, e_any, sig_fall;
  logic hold_n, fin_n, ovf_n;
  logic [1:0] mode_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CHARGE_W-1:0] charge_n;
  logic [31:0] unit_fee;
  logic [TW-1:0] tmo, tmo_n;
  logic [SW-1:0] sc;
  logic [IW-1:0] di, idx;
  logic [VW-1:0] val;
  logic [7:0] dec_seg, seg_n;
  assign {e_one, e_ten, e_high, e_low, e_cancel} = {one, ten, high, low, cancel} & ~prev[4:0];
  assign e_any = |{e_one, e_ten, e_high, e_low, e_cancel};
  assign sig_fall = prev[5] & ~signal;
  assign unit_fee = 32'(cnt) * 32'(UNIT_FEE);
  assign work = st != S_OFF;
  assign state = st;
  always_comb begin
    st_n = st;
    hold_n = hold_in;
    mode_n = mode;
    cnt_n = cnt;
    charge_n = charge;
    fin_n = fin;
    ovf_n = overflow;
    tmo_n = '0;
    // unplug wins over every button edge seen in the same cycle
    if (sig_fall && (st == S_HOLD || st == S_RUN || st == S_DONE)) begin
      st_n = S_IDLE;
      hold_n = 1'b0;
      mode_n = MODE_NONE;
      cnt_n = '0;
      charge_n = '0;
      fin_n = 1'b0;
      ovf_n = 1'b0;
    end else begin
      case (st)
        S_OFF: st_n = S_IDLE;
        S_IDLE: if (signal) begin
          st_n = S_HOLD;
          hold_n = 1'b1;
        end
        S_HOLD: if (e_one) begin
          st_n = S_RUN;
          mode_n = MODE_UNIT;
          cnt_n = CNT_W'(1);
        end else if (e_ten) begin
          st_n = S_RUN;
          mode_n = MODE_PKG;
        end else if (e_cancel || tmo == TW'(TIMEOUT_CYC - 1)) begin
          st_n = S_IDLE;
          hold_n = 1'b0;
        end else tmo_n = e_any ? '0 : tmo + 1'b1;
        S_RUN: if (mode == MODE_UNIT) begin
          if (e_cancel || (e_low && cnt >= CNT_W'(DISC_MIN))) begin
            charge_n = sat(e_cancel ? unit_fee : unit_fee + 32'(BONUS));
            fin_n = 1'b1;
            st_n = S_DONE;
          end else if (e_one && !overflow) begin
            cnt_n = cnt + 1'b1;
            ovf_n = cnt + 1'b1 == CNT_W'(MAX_UNITS);
          end
        end else if (e_high || e_low || e_cancel) begin
          charge_n = sat(e_high ? 32'(PKG_HIGH) : e_low ? 32'(PKG_LOW) : 32'(PKG_FULL));
          fin_n = 1'b1;
          st_n = S_DONE;
        end
        default: ;
      endcase
    end
  end
  // in S_DONE digit 0 is the half-unit, so the integer part starts at digit 1
  assign val = st == S_DONE ? VW'(charge >> 1) : VW'(cnt);
  assign idx = st == S_DONE ? di - 1'b1 : di;
  seg_bcd_decode #(.VAL_W(VW), .DIGITS(DIGITS)) u_dec (.val(val), .idx(idx), .seg(dec_seg));
  always_comb
    seg_n = st == S_OFF ? SEG_BLANK :
            st == S_IDLE ? SEG_DASH :
            st != S_DONE ? dec_seg :
            di == '0 ? seg_of(charge[0] ? 4'd5 : 4'd0) :
            di == IW'(1) ? dec_seg & SEG_DP : dec_seg;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= S_OFF;
      prev <= '0;
      hold_in <= 1'b0;
      mode <= MODE_NONE;
      cnt <= '0;
      charge <= '0;
      fin <= 1'b0;
      overflow <= 1'b0;
      tmo <= '0;
      sc <= '0;
      di <= '0;
      en <= '1;
      show <= SEG_BLANK;
    end else begin
      st <= st_n;
      prev <= {signal, one, ten, high, low, cancel};
      hold_in <= hold_n;
      mode <= mode_n;
      cnt <= cnt_n;
      charge <= charge_n;
      fin <= fin_n;
      overflow <= ovf_n;
      tmo <= tmo_n;
      sc <= sc == SW'(SCAN_DIV - 1) ? '0 : sc + 1'b1;
      if (sc == SW'(SCAN_DIV - 1)) di <= di == IW'(DIGITS - 1) ? '0 : di + 1'b1;
      en <= st == S_OFF ? '1 : ~(DIGITS'(1) << di);
      show <= seg_n;
    end
endmodule

// File: tb/tb_charge_meter_ctrl.sv
// tb_charge_meter_ctrl: directed checks of session flow, fees, timeout, unplug, reset and display scan
module tb_charge_meter_ctrl;
  localparam int TO = 20;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic reset = 1'b0, signal = 1'b0, one = 1'b0, ten = 1'b0, high = 1'b0, low = 1'b0, cancel = 1'b0;
  logic work, hold_in, fin, overflow;
  logic [1:0] mode;
  logic [2:0] state;
  logic [3:0] cnt, en;
  logic [7:0] charge, show;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  charge_meter_ctrl #(.TIMEOUT_CYC(TO), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .signal(signal), .one(one), .ten(ten), .high(high), .low(low),
    .cancel(cancel), .work(work), .hold_in(hold_in), .mode(mode), .state(state), .cnt(cnt),
    .charge(charge), .fin(fin), .overflow(overflow), .en(en), .show(show)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  // bits: one, ten, high, low, cancel
  task automatic press(input logic [4:0] b);
    {one, ten, high, low, cancel} = b;
    step();
    {one, ten, high, low, cancel} = '0;
    step();
  endtask
  task automatic digit_chk(input int d, input logic [7:0] exp, input string tag);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << d);
    n = 0;
    while (en !== want && n < 64) begin
      step();
      n++;
    end
    chk({tag, "_found"}, 32'(n < 64), 32'd1);
    chk(tag, {24'd0, show}, {24'd0, exp});
  endtask
  initial begin
    int n;
    logic [3:0] prev, w;
    step(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_work", 32'(work), 32'd0);
    chk("rst_en", 32'(en), 32'hF);
    chk("rst_show", 32'(show), 32'hFF);
    chk("rst_fin", 32'(fin), 32'd0);
    reset = 1'b1;
    step();
    chk("boot_state", 32'(state), 32'd1);
    chk("boot_work", 32'(work), 32'd1);
    // unit mode, three units, cancel settles
    signal = 1'b1;
    step();
    chk("hold_state", 32'(state), 32'd2);
    chk("hold_in", 32'(hold_in), 32'd1);
    press(5'b10000);
    chk("run_state", 32'(state), 32'd3);
    chk("run_mode", 32'(mode), 32'd1);
    chk("run_cnt1", 32'(cnt), 32'd1);
    press(5'b10000);
    press(5'b10000);
    press(5'b00001);
    chk("t1_cnt", 32'(cnt), 32'd3);
    chk("t1_charge", 32'(charge), 32'd6);
    chk("t1_fin", 32'(fin), 32'd1);
    chk("t1_state", 32'(state), 32'd4);
    digit_chk(0, 8'hC0, "t1_d0");
    digit_chk(1, 8'h30, "t1_d1");
    digit_chk(2, 8'hFF, "t1_d2");
    digit_chk(3, 8'hFF, "t1_d3");
    signal = 1'b0;
    step();
    chk("t1_unplug_state", 32'(state), 32'd1);
    chk("t1_unplug_cnt", 32'(cnt), 32'd0);
    chk("t1_unplug_fin", 32'(fin), 32'd0);
    // unit mode overflow, low with discount
    signal = 1'b1;
    step();
    repeat (4) press(5'b10000);
    chk("t2_cnt4", 32'(cnt), 32'd4);
    chk("t2_ovf_pre", 32'(overflow), 32'd0);
    press(5'b10000);
    chk("t2_cnt5", 32'(cnt), 32'd5);
    chk("t2_ovf", 32'(overflow), 32'd1);
    press(5'b10000);
    chk("t2_cnt_sat", 32'(cnt), 32'd5);
    press(5'b00010);
    chk("t2_charge", 32'(charge), 32'd16);
    chk("t2_fin", 32'(fin), 32'd1);
    digit_chk(1, 8'h00, "t2_d1");
    digit_chk(0, 8'hC0, "t2_d0");
    signal = 1'b0;
    step();
    // package mode, high beats simultaneous low
    signal = 1'b1;
    step();
    press(5'b01000);
    chk("t3_mode", 32'(mode), 32'd3);
    chk("t3_state", 32'(state), 32'd3);
    press(5'b00110);
    chk("t3_charge", 32'(charge), 32'd10);
    chk("t3_fin", 32'(fin), 32'd1);
    signal = 1'b0;
    step();
    chk("t3_state_idle", 32'(state), 32'd1);
    chk("t3_hold", 32'(hold_in), 32'd0);
    chk("t3_mode_clr", 32'(mode), 32'd0);
    chk("t3_charge_clr", 32'(charge), 32'd0);
    chk("t3_fin_clr", 32'(fin), 32'd0);
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    digit_chk(2, 8'hBF, "idle_dash");
    // idle timeout in S_HOLD
    signal = 1'b1;
    step();
    chk("t4_hold", 32'(state), 32'd2);
    step(TO - 1);
    chk("t4_still_hold", 32'(state), 32'd2);
    step();
    chk("t4_timeout_state", 32'(state), 32'd1);
    chk("t4_timeout_hold", 32'(hold_in), 32'd0);
    step();
    chk("t4_rehold", 32'(state), 32'd2);
    step(10);
    press(5'b10000);
    chk("t4_run", 32'(state), 32'd3);
    chk("t4_mode", 32'(mode), 32'd1);
    press(5'b10000);
    press(5'b00010);
    chk("t4_low_ign_state", 32'(state), 32'd3);
    chk("t4_low_ign_fin", 32'(fin), 32'd0);
    chk("t4_low_ign_cnt", 32'(cnt), 32'd2);
    digit_chk(0, 8'hA4, "t4_d0");
    digit_chk(1, 8'hFF, "t4_d1");
    // digit scan order and slot length
    n = 0;
    prev = en;
    while (!(en == 4'b1110 && prev != 4'b1110) && n < 64) begin
      prev = en;
      step();
      n++;
    end
    chk("scan_sync", 32'(n < 64), 32'd1);
    for (int k = 0; k < 8; k++) begin
      w = ~(4'b0001 << (k % 4));
      chk("scan_start", 32'(en), 32'(w));
      step(SD - 1);
      chk("scan_end", 32'(en), 32'(w));
      step();
    end
    // asynchronous reset mid-session
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_work", 32'(work), 32'd0);
    chk("arst_cnt", 32'(cnt), 32'd0);
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_hold", 32'(hold_in), 32'd0);
    chk("arst_en", 32'(en), 32'hF);
    chk("arst_show", 32'(show), 32'hFF);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("arst_idle", 32'(state), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
